spi_slave_port: RTL and testbench

- SPI slave endpoint on one bit of an 8-bit active-low slave-select bus, driven by the SPI master core.
- Oversamples SCLK, MOSI and SS with the system clock and deserialises MOSI into words.
- Serialises a preloaded transmit word onto MISO.
- Presents received words to local logic with a single-cycle valid strobe.

---
 rtl/spi_slave_port.sv | 142 ++++++++++++++
 tb/tb_spi_slave_port.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// SPI slave endpoint: oversamples SCLK/MOSI/SS, deserialises MOSI words and serialises a held word onto MISO.
// Latency: pin changes act 3 clocks later; rx_valid rises 1 clock after the completing sample edge is detected.
// Backpressure: none; rx_valid is a one-cycle strobe and local logic must take rx_data when it fires.
module spi_slave_port #(
    parameter int   SLAVE_ID  = 0,
    parameter int   DATA_W    = 8,
    parameter logic CPOL      = 1'b0,
    parameter logic CPHA      = 1'b0,
    parameter logic LSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [7:0]        ss_pad_o,
    input  logic              sclk,
    input  logic              mosi_pad_o,
    output logic              miso_pad_i,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Only one select bit belongs to this slave; the rest are deliberately ignored.
    logic unused_ss;
    assign unused_ss = &{1'b0, ss_pad_o};

    logic sel_s1, sel_s2, sel_s3;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] hold_q;
    logic              reload_pend;

    logic              sel_fall, sel_rise;
    logic              lead_edge, trail_edge;
    logic              sample_edge, shift_edge;
    logic [DATA_W-1:0] hold_nxt;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] tx_shifted;

    // Bit that goes on the wire first for a given word in the configured order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    assign sel_fall    = sel_s3 & ~sel_s2;
    assign sel_rise    = ~sel_s3 & sel_s2;
    assign lead_edge   = (sclk_s3 == CPOL) && (sclk_s2 != CPOL);
    assign trail_edge  = (sclk_s3 != CPOL) && (sclk_s2 == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    // A load in the same cycle as a reload point wins, so the fresh value goes out.
    assign hold_nxt    = tx_load ? tx_data : hold_q;
    assign rx_word     = LSB_FIRST ? {mosi_s2, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_s2};
    assign tx_shifted  = LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);

    // Two-flop synchronisers plus a third SS/SCLK stage used only for edge detection.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sel_s1  <= 1'b1;
            sel_s2  <= 1'b1;
            sel_s3  <= 1'b1;
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_s3 <= CPOL;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sel_s1  <= ss_pad_o[SLAVE_ID];
            sel_s2  <= sel_s1;
            sel_s3  <= sel_s2;
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= mosi_pad_o;
            mosi_s2 <= mosi_s1;
        end
    end

    // Frame control, receive deserialiser, transmit serialiser and holding register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            miso_pad_i  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            hold_q      <= '0;
            reload_pend <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            hold_q   <= hold_nxt;
            if (sel_rise) begin
                // Deselect drops any partial word and parks MISO low.
                busy        <= 1'b0;
                bit_cnt     <= '0;
                miso_pad_i  <= 1'b0;
                reload_pend <= 1'b0;
            end else if (sel_fall) begin
                busy        <= 1'b1;
                bit_cnt     <= '0;
                rx_sr       <= '0;
                tx_sr       <= hold_nxt;
                // With CPHA=1 the first leading edge is a reload point that drives bit 0.
                reload_pend <= CPHA;
                miso_pad_i  <= CPHA ? 1'b0 : first_bit(hold_nxt);
            end else if (busy) begin
                if (sample_edge) begin
                    rx_sr <= rx_word;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt     <= '0;
                        rx_data     <= rx_word;
                        rx_valid    <= 1'b1;
                        reload_pend <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (reload_pend) begin
                        tx_sr       <= hold_nxt;
                        miso_pad_i  <= first_bit(hold_nxt);
                        reload_pend <= 1'b0;
                    end else begin
                        tx_sr      <= tx_shifted;
                        miso_pad_i <= first_bit(tx_shifted);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
module tb_spi_slave_port;

    localparam int HALF = 5;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ss_pad_o = 8'hFF;
    logic       sclk0 = 1'b0;
    logic       sclk3 = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       miso0, miso3, rxv0, rxv3, busy0, busy3;
    logic [7:0] rxd0, rxd3;

    int total = 0;
    int bad = 0;
    int dbl = 0;
    logic pv0 = 1'b0;
    logic pv3 = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q3[$];

    logic [7:0] fr_tx[4];
    logic [7:0] fr_mo[4];
    logic [7:0] fr_mi[4];
    logic       busy_all, busy_any;

    typedef struct {
        int         mode;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;
    vec_t vt[4];

    // Mode 0, MSB first, slave 0.
    spi_slave_port #(.SLAVE_ID(0), .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) dut0 (
        .clock(clock), .rst_n(rst_n), .ss_pad_o(ss_pad_o), .sclk(sclk0), .mosi_pad_o(mosi),
        .miso_pad_i(miso0), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0));

    // Mode 3, LSB first, slave 2.
    spi_slave_port #(.SLAVE_ID(2), .DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) dut3 (
        .clock(clock), .rst_n(rst_n), .ss_pad_o(ss_pad_o), .sclk(sclk3), .mosi_pad_o(mosi),
        .miso_pad_i(miso3), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rxd3), .rx_valid(rxv3), .busy(busy3));

    always #5 clock = ~clock;

    // Collect every received word and flag strobes longer than one clock.
    always @(negedge clock) begin
        if (rxv0 === 1'b1) q0.push_back(rxd0);
        if (rxv3 === 1'b1) q3.push_back(rxd3);
        if (rxv0 === 1'b1 && pv0 === 1'b1) dbl++;
        if (rxv3 === 1'b1 && pv3 === 1'b1) dbl++;
        pv0 = rxv0;
        pv3 = rxv3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    // Master side: loads fr_tx[0], asserts ssv, clocks nw words of nbits each,
    // loading fr_tx[w+1] mid-way through word w, and records MISO into fr_mi.
    task automatic frame(input int mode, input int nw, input int nbits, input logic [7:0] ssv);
        int idx;
        busy_all = 1'b1;
        busy_any = 1'b0;
        for (int w = 0; w < 4; w++) fr_mi[w] = 8'h00;
        load(fr_tx[0]);
        ss_pad_o = ssv;
        tick(6);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < nbits; b++) begin
                idx = (mode == 0) ? 7 - b : b;
                if (mode == 0) begin
                    mosi = fr_mo[w][idx];
                    tick(HALF);
                    fr_mi[w][idx] = miso0;
                    busy_all &= busy0;
                    busy_any |= busy0;
                    sclk0 = 1'b1;
                    tick(HALF);
                    sclk0 = 1'b0;
                end else begin
                    sclk3 = 1'b0;
                    mosi = fr_mo[w][idx];
                    tick(HALF);
                    fr_mi[w][idx] = miso3;
                    busy_all &= busy3;
                    busy_any |= busy3;
                    sclk3 = 1'b1;
                    tick(HALF);
                end
                if (b == 3 && w + 1 < nw) load(fr_tx[w + 1]);
            end
        end
        tick(6);
        ss_pad_o = 8'hFF;
        tick(6);
    endtask

    task automatic post_checks(input int mode, input string tag);
        chk($sformatf("%s_busy_during", tag), busy_all, 1'b1);
        chk($sformatf("%s_busy_after", tag), (mode == 0) ? busy0 : busy3, 1'b0);
        chk($sformatf("%s_miso_after", tag), (mode == 0) ? miso0 : miso3, 1'b0);
        chk($sformatf("%s_strobe_len", tag), dbl, 0);
    endtask

    task automatic check_words(input int mode, input int nw, input string tag);
        int n;
        n = (mode == 0) ? q0.size() : q3.size();
        chk($sformatf("%s_nrx", tag), n, nw);
        for (int w = 0; w < nw; w++) begin
            if (w < n) chk($sformatf("%s_rx%0d", tag, w), (mode == 0) ? q0[w] : q3[w], fr_mo[w]);
            chk($sformatf("%s_miso%0d", tag, w), fr_mi[w], fr_tx[w]);
        end
        post_checks(mode, tag);
        q0.delete();
        q3.delete();
    endtask

    initial begin
        int mode, nw, n;

        vt[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vt[1] = '{3, 8'h35, 8'h01, 8'h01, 8'h35};
        vt[2] = '{0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vt[3] = '{3, 8'hC4, 8'h80, 8'h80, 8'hC4};

        // Reset with other inputs toggling.
        ss_pad_o = 8'h00; sclk0 = 1'b1; sclk3 = 1'b0; mosi = 1'b1; tx_data = 8'hFF; tx_load = 1'b1;
        tick(1);
        ss_pad_o = 8'hAA; sclk0 = 1'b0; sclk3 = 1'b1; mosi = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_miso0", miso0, 1'b0);
        chk("rst_rxv0", rxv0, 1'b0);
        chk("rst_rxd0", rxd0, 8'h00);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_miso3", miso3, 1'b0);
        chk("rst_rxv3", rxv3, 1'b0);
        chk("rst_rxd3", rxd3, 8'h00);
        chk("rst_busy3", busy3, 1'b0);
        ss_pad_o = 8'hFF; sclk0 = 1'b0; sclk3 = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        q0.delete();
        q3.delete();

        // Table of single-word exchanges in both modes.
        for (int i = 0; i < 4; i++) begin
            fr_tx[0] = vt[i].tx;
            fr_mo[0] = vt[i].mo;
            frame(vt[i].mode, 1, 8, (vt[i].mode == 0) ? 8'hFE : 8'hFB);
            n = (vt[i].mode == 0) ? q0.size() : q3.size();
            chk($sformatf("vec%0d_nrx", i), n, 1);
            if (n > 0) chk($sformatf("vec%0d_rx", i), (vt[i].mode == 0) ? q0[0] : q3[0], vt[i].exp_rx);
            chk($sformatf("vec%0d_miso", i), fr_mi[0], vt[i].exp_mi);
            post_checks(vt[i].mode, $sformatf("vec%0d", i));
            q0.delete();
            q3.delete();
        end

        // Back-to-back words under one select; second word carries the newly held value.
        fr_tx[0] = 8'hC3; fr_tx[1] = 8'h96;
        fr_mo[0] = 8'h81; fr_mo[1] = 8'h7E;
        frame(0, 2, 8, 8'hFE);
        check_words(0, 2, "b2b");
        chk("b2b_rxd_last", rxd0, 8'h7E);

        // Abort after 5 bits: nothing delivered, previous word kept.
        fr_tx[0] = 8'hFF; fr_mo[0] = 8'hAB;
        frame(0, 1, 5, 8'hFE);
        chk("abort_nrx", q0.size(), 0);
        chk("abort_rxd", rxd0, 8'h7E);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_miso", miso0, 1'b0);

        // Another slave selected: this port stays idle.
        fr_tx[0] = 8'hFF; fr_mo[0] = 8'h55;
        frame(0, 1, 8, 8'hFD);
        chk("wsel_nrx0", q0.size(), 0);
        chk("wsel_nrx3", q3.size(), 0);
        chk("wsel_busy", busy_any, 1'b0);
        chk("wsel_miso", fr_mi[0], 8'h00);
        chk("wsel_rxd", rxd0, 8'h7E);
        q0.delete();
        q3.delete();

        // Randomised multi-word frames: every word sent is received, every held word is sent.
        for (int r = 0; r < 16; r++) begin
            mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                fr_tx[w] = 8'($urandom);
                fr_mo[w] = 8'($urandom);
            end
            frame(mode, nw, 8, (mode == 0) ? 8'hFE : 8'hFB);
            check_words(mode, nw, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
